// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control unit. It holds the following:
//   - The reset level (RstEnable) and the per-stage stall levels (Stop/NoStop).
//   - ZeroWord.
//   - The exception type codes and exception vector addresses.
//   - The encodings of the control FSM states.
//   - A helper that maps an exception type to its redirect PC.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic        RstEnable = 1'b0;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Exception type codes reported by the MEM stage
  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK     = 32'h0000_0009;
  localparam logic [31:0] EXC_INVALID   = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  // Exception vector addresses
  localparam logic [31:0] VEC_INTERRUPT = 32'h0000_0020;
  localparam logic [31:0] VEC_EXCEPTION = 32'h0000_0040;

  // Stall vectors, bit0 = PC ... bit5 = WB
  localparam logic [5:0] STALL_NONE = {6{NoStop}};
  localparam logic [5:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop, Stop, Stop};
  localparam logic [5:0] STALL_EX   = {NoStop, NoStop, Stop, Stop, Stop, Stop};

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_STALL_ID = 2'd1,
    CTRL_STALL_EX = 2'd2,
    CTRL_FLUSH    = 2'd3
  } ctrl_state_t;

  // Redirect target for a nonzero exception type. The synchronous exception
  // codes and any unknown code all share the general exception vector.
  function automatic logic [31:0] exc_vector(input logic [31:0] exc_type,
                                             input logic [31:0] epc);
    logic [31:0] v;
    case (exc_type)
      EXC_INTERRUPT: v = VEC_INTERRUPT;
      EXC_ERET:      v = epc;
      default:       v = VEC_EXCEPTION;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_wdog
// Consecutive-stall watchdog. It counts the cycles in which the pipeline is
// stalled and not flushed. The counter clears on any cycle that is not a stall.
// The flag latches when the current cycle is still stalled and the count
// already reads STALL_LIMIT-1.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active low (RstEnable)
//   i_stall_active this cycle is a stall cycle (stall != 0 and no flush)
//   o_timeout      sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall_active,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (i_stall_active) begin
      // Use >= so that the flag stays set once the counter has saturated
      if (r_cnt >= LIMIT_M1) begin
        r_timeout <= 1'b1;
      end
      if (r_cnt != LIMIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the five-stage datapath.
//   - Stall, flush and new_pc are combinational and take effect in the same
//     cycle as the request.
//   - Priority, highest first: reset, then exception, then EX stall, then
//     ID stall.
//   - ctrl_state_o holds the previous cycle's decision.
//   - The watchdog lives in pipe_ctrl_wdog.
// Optional feature: define PIPE_CTRL_PERF_EN to build saturating 32-bit
// counters for ID-stall, EX-stall and flush cycles. With the macro undefined,
// the three perf ports read 0.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   stallreq_from_id/ex            stall requests from ID / EX
//   excepttype_i, cp0_epc_i        exception type (0 = none), EPC for eret
//   stall[5:0], flush, new_pc      pipeline control outputs
//   ctrl_state_o, stall_timeout_o  registered state, sticky watchdog flag
//   perf_*_o                       performance counters
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  ctrl_state_o,
  output logic        stall_timeout_o,
  output logic [31:0] perf_id_stall_o,
  output logic [31:0] perf_ex_stall_o,
  output logic [31:0] perf_flush_o
);

  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  ctrl_state_t w_class;
  logic        w_stall_active;
  ctrl_state_t r_state;

  always_comb begin
    w_stall  = STALL_NONE;
    w_flush  = 1'b0;
    w_new_pc = ZeroWord;
    w_class  = CTRL_RUN;
    if (rst != RstEnable) begin
      if (excepttype_i != ZeroWord) begin
        w_flush  = 1'b1;
        w_new_pc = exc_vector(excepttype_i, cp0_epc_i);
        w_class  = CTRL_FLUSH;
      end else if (stallreq_from_ex) begin
        w_stall = STALL_EX;
        w_class = CTRL_STALL_EX;
      end else if (stallreq_from_id) begin
        w_stall = STALL_ID;
        w_class = CTRL_STALL_ID;
      end
    end
  end

  assign stall  = w_stall;
  assign flush  = w_flush;
  assign new_pc = w_new_pc;

  // Records the class of each cycle's decision, lagging it by one cycle
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= CTRL_RUN;
    end else begin
      r_state <= w_class;
    end
  end

  assign ctrl_state_o = r_state;

  assign w_stall_active = (w_stall != STALL_NONE) && !w_flush;

  pipe_ctrl_wdog #(
    .STALL_LIMIT(STALL_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wdog (
    .clk           (clk),
    .rst           (rst),
    .i_stall_active(w_stall_active),
    .o_timeout     (stall_timeout_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_id;
  logic [31:0] r_perf_ex;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_perf_id    <= '0;
      r_perf_ex    <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_class == CTRL_STALL_ID && r_perf_id != '1) begin
        r_perf_id <= r_perf_id + 32'd1;
      end
      if (w_class == CTRL_STALL_EX && r_perf_ex != '1) begin
        r_perf_ex <= r_perf_ex + 32'd1;
      end
      if (w_class == CTRL_FLUSH && r_perf_flush != '1) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_id_stall_o = r_perf_id;
  assign perf_ex_stall_o = r_perf_ex;
  assign perf_flush_o    = r_perf_flush;
`else
  assign perf_id_stall_o = ZeroWord;
  assign perf_ex_stall_o = ZeroWord;
  assign perf_flush_o    = ZeroWord;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Scoreboard bench for pipe_ctrl, built with STALL_LIMIT = 4.
//   - The stimulus process drives one transaction per cycle, 1 ns after the
//     rising edge.
//   - For each transaction it pushes the expected outputs into a queue. These
//     come from a reference model built on cycle classes and run lengths.
//   - The monitor pops the queue and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_req = 1'b0;
  logic        ex_req = 1'b0;
  logic [31:0] exc = 32'h0;
  logic [31:0] epc = 32'h0;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state_o;
  logic        stall_timeout_o;
  logic [31:0] perf_id_stall_o;
  logic [31:0] perf_ex_stall_o;
  logic [31:0] perf_flush_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_from_id(id_req),
    .stallreq_from_ex(ex_req),
    .excepttype_i    (exc),
    .cp0_epc_i       (epc),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .ctrl_state_o    (ctrl_state_o),
    .stall_timeout_o (stall_timeout_o),
    .perf_id_stall_o (perf_id_stall_o),
    .perf_ex_stall_o (perf_ex_stall_o),
    .perf_flush_o    (perf_flush_o)
  );

  typedef struct {
    int          cyc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        to;
    logic [31:0] pid;
    logic [31:0] pex;
    logic [31:0] pfl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;

  // Reference model state, describing what has happened before the current cycle:
  //   m_prev         class of the previous cycle's decision
  //                  (0 run, 1 id, 2 ex, 3 flush)
  //   m_run          length of the current run of consecutive stalled cycles
  //   m_to           sticky timeout flag
  //   m_nid/nex/nfl  cycle counts since the last reset
  int          m_prev = 0;
  int          m_run  = 0;
  bit          m_to   = 1'b0;
  int unsigned m_nid  = 0;
  int unsigned m_nex  = 0;
  int unsigned m_nfl  = 0;

  function automatic void chk(string name, int cyc, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, req);
    end
  endfunction

  task automatic drive(input bit r, input bit i, input bit e,
                       input logic [31:0] t, input logic [31:0] p);
    exp_t x;
    int   cls;
    @(posedge clk);
    #1;
    rst = r; id_req = i; ex_req = e; exc = t; epc = p;
    cyc_no++;
    x.cyc = cyc_no;
    x.st  = 2'(m_prev);
    x.to  = m_to;
`ifdef PIPE_CTRL_PERF_EN
    x.pid = m_nid;
    x.pex = m_nex;
    x.pfl = m_nfl;
`else
    x.pid = 32'h0;
    x.pex = 32'h0;
    x.pfl = 32'h0;
`endif
    x.stall = 6'b0; x.flush = 1'b0; x.pc = 32'h0; cls = 0;
    if (r) begin
      if (t != 0) begin
        cls = 3; x.flush = 1'b1;
        if (t == 32'h1)      x.pc = 32'h20;
        else if (t == 32'he) x.pc = p;
        else                 x.pc = 32'h40;
      end else if (e) begin
        cls = 2; x.stall = 6'b001111;
      end else if (i) begin
        cls = 1; x.stall = 6'b000111;
      end
    end
    q.push_back(x);
    if (!r) begin
      m_prev = 0; m_run = 0; m_to = 1'b0; m_nid = 0; m_nex = 0; m_nfl = 0;
    end else begin
      m_prev = cls;
      if (cls == 1 || cls == 2) begin
        if (m_run < 1000) m_run++;
        if (m_run >= LIMIT) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
      if (cls == 1) m_nid++;
      if (cls == 2) m_nex++;
      if (cls == 3) m_nfl++;
    end
  endtask

  // Monitor: the outputs are presented every cycle, so one entry is popped
  // on each falling edge
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("stall",   x.cyc, 32'(stall),           32'(x.stall));
      chk("flush",   x.cyc, 32'(flush),           32'(x.flush));
      chk("new_pc",  x.cyc, new_pc,               x.pc);
      chk("state",   x.cyc, 32'(ctrl_state_o),    32'(x.st));
      chk("timeout", x.cyc, 32'(stall_timeout_o), 32'(x.to));
      chk("perf_id", x.cyc, perf_id_stall_o,      x.pid);
      chk("perf_ex", x.cyc, perf_ex_stall_o,      x.pex);
      chk("perf_fl", x.cyc, perf_flush_o,         x.pfl);
      $display("txn %0d rst=%0b id=%0b ex=%0b exc=%h stall=%b flush=%0b pc=%h st=%0d to=%0b perf=%0d/%0d/%0d",
               x.cyc, rst, id_req, ex_req, exc, stall, flush, new_pc, ctrl_state_o,
               stall_timeout_o, perf_id_stall_o, perf_ex_stall_o, perf_flush_o);
    end
  end

  logic [31:0] exc_list [8];
  bit          ex_hold;

  initial begin
    exc_list[0] = 32'h1; exc_list[1] = 32'h8; exc_list[2] = 32'h9; exc_list[3] = 32'ha;
    exc_list[4] = 32'hc; exc_list[5] = 32'hd; exc_list[6] = 32'he; exc_list[7] = 32'h77;

    // Reset held for 3 cycles with both stall requests high
    repeat (3) drive(0, 1, 1, 32'h0, 32'h0);
    // A single-cycle ID stall
    drive(1, 1, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    // An eret with both stall requests high
    drive(1, 1, 1, 32'he, 32'h8000_1234);
    drive(1, 0, 0, 32'h0, 32'h0);
    // Exception vectors, then an EX stall
    drive(1, 0, 0, 32'h1, 32'h0);
    drive(1, 0, 0, 32'hc, 32'h0);
    drive(1, 0, 1, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h8, 32'h0);
    drive(1, 0, 0, 32'h9, 32'h0);
    drive(1, 0, 0, 32'ha, 32'h0);
    drive(1, 0, 0, 32'hd, 32'h0);
    drive(1, 0, 0, 32'h1234_5678, 32'hdead_beef);
    // Watchdog: a 3-cycle stall does not time out; a 4-cycle stall does and
    // the flag stays sticky until reset
    repeat (3) drive(1, 0, 1, 32'h0, 32'h0);
    repeat (2) drive(1, 0, 0, 32'h0, 32'h0);
    repeat (4) drive(1, 0, 1, 32'h0, 32'h0);
    repeat (3) drive(1, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (2) drive(1, 0, 0, 32'h0, 32'h0);
    // A flush in the middle of a stall restarts the run
    repeat (3) drive(1, 1, 1, 32'h0, 32'h0);
    drive(1, 1, 1, 32'h8, 32'h0);
    repeat (3) drive(1, 1, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    // Performance counters: 5 ID-stall cycles, 2 EX-stall cycles, 1 flush
    drive(0, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, 32'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 32'h0);
    end
    drive(1, 0, 1, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 1, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h1, 32'h0);
    repeat (2) drive(1, 0, 0, 32'h0, 32'h0);
    // Random traffic: occasional resets, long EX runs, rare exceptions
    ex_hold = 1'b0;
    for (int n = 0; n < 500; n++) begin
      bit          r;
      bit          i;
      logic [31:0] t;
      r = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 3) == 0) ex_hold = ~ex_hold;
      i = ($urandom_range(0, 2) == 0);
      t = 32'h0;
      if ($urandom_range(0, 11) == 0) t = exc_list[$urandom_range(0, 7)];
      drive(r, i, ex_hold, t, $urandom);
    end
    drive(1, 0, 0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
